// File: rtl/mouse_bus_io.sv
// Bus-mapped PS/2 mouse peripheral: assembles 3-byte packets, keeps clamped X/Y
// position plus raw packet registers, and raises an interrupt per committed packet.
module mouse_bus_io #(
  parameter logic [7:0]  BASE_ADDR = 8'hA0,
  parameter int unsigned X_MAX     = 159,
  parameter int unsigned Y_MAX     = 119,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [7:0] RX_BYTE,
  input  logic       RX_VALID,
  input  logic       RX_ERROR,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int unsigned GW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LIMIT = GW'(TIMEOUT);
  localparam logic [7:0] X_RST = 8'(X_MAX / 2);
  localparam logic [7:0] Y_RST = 8'(Y_MAX / 2);
  localparam logic signed [10:0] X_LIM = 11'(X_MAX);
  localparam logic signed [10:0] Y_LIM = 11'(Y_MAX);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, COMMIT} state_t;

  state_t state, state_n;
  logic [GW-1:0] gap, gap_n;
  logic [7:0] b0, b1, b2;
  logic ld0, ld1, ld2, commit;

  logic [7:0] status, x, y, dx_r, dy_r, ctrl, pkt_cnt;
  logic       rd_en;
  logic [7:0] rd_data, rd_mux;

  logic [7:0] off;
  logic       in_win, wr_ctrl, recenter;

  logic signed [10:0] dx, dy, xs, ys;
  logic [7:0] x_cl, y_cl;

  assign off      = BUS_ADDR - BASE_ADDR;
  assign in_win   = (off < 8'd8);
  assign wr_ctrl  = in_win && BUS_WE && (off[2:0] == 3'd5);
  assign recenter = wr_ctrl && BUS_DATA[1];
  assign commit   = (state == COMMIT);

  assign BUS_DATA = rd_en ? rd_data : 'z;

  // Packet framing; COMMIT also accepts the first byte of the next packet.
  always_comb begin
    state_n = state;
    gap_n   = '0;
    ld0     = 1'b0;
    ld1     = 1'b0;
    ld2     = 1'b0;
    case (state)
      WAIT_B0, COMMIT: begin
        state_n = WAIT_B0;
        if (!RX_ERROR && RX_VALID && RX_BYTE[3]) begin
          state_n = WAIT_B1;
          ld0     = 1'b1;
        end
      end
      WAIT_B1: begin
        if (RX_ERROR || gap == GAP_LIMIT) begin
          state_n = WAIT_B0;
        end else if (RX_VALID) begin
          state_n = WAIT_B2;
          ld1     = 1'b1;
        end else begin
          gap_n = gap + 1'b1;
        end
      end
      WAIT_B2: begin
        if (RX_ERROR || gap == GAP_LIMIT) begin
          state_n = WAIT_B0;
        end else if (RX_VALID) begin
          state_n = COMMIT;
          ld2     = 1'b1;
        end else begin
          gap_n = gap + 1'b1;
        end
      end
      default: state_n = WAIT_B0;
    endcase
  end

  // Sign-extended 9-bit deltas, zeroed on overflow flags, then clamped.
  always_comb begin
    dx = b0[6] ? '0 : {{3{b0[4]}}, b1};
    dy = b0[7] ? '0 : {{3{b0[5]}}, b2};
    xs = $signed({3'b000, x}) + dx;
    ys = $signed({3'b000, y}) - dy;
    if (xs < 11'sd0)      x_cl = '0;
    else if (xs > X_LIM)  x_cl = X_LIM[7:0];
    else                  x_cl = xs[7:0];
    if (ys < 11'sd0)      y_cl = '0;
    else if (ys > Y_LIM)  y_cl = Y_LIM[7:0];
    else                  y_cl = ys[7:0];
  end

  always_comb begin
    rd_mux = '0;
    case (off[2:0])
      3'd0: rd_mux = status;
      3'd1: rd_mux = x;
      3'd2: rd_mux = y;
      3'd3: rd_mux = dx_r;
      3'd4: rd_mux = dy_r;
      3'd5: rd_mux = ctrl;
      3'd6: rd_mux = pkt_cnt;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state               <= WAIT_B0;
      gap                 <= '0;
      b0                  <= '0;
      b1                  <= '0;
      b2                  <= '0;
      status              <= '0;
      x                   <= X_RST;
      y                   <= Y_RST;
      dx_r                <= '0;
      dy_r                <= '0;
      ctrl                <= 8'h01;
      pkt_cnt             <= '0;
      BUS_INTERRUPT_RAISE <= 1'b0;
      rd_en               <= 1'b0;
      rd_data             <= '0;
    end else begin
      state <= state_n;
      gap   <= gap_n;
      if (ld0) b0 <= RX_BYTE;
      if (ld1) b1 <= RX_BYTE;
      if (ld2) b2 <= RX_BYTE;

      rd_en   <= in_win && !BUS_WE;
      rd_data <= rd_mux;

      if (commit) begin
        status  <= b0;
        dx_r    <= b1;
        dy_r    <= b2;
        pkt_cnt <= pkt_cnt + 8'd1;
      end

      if (recenter) begin
        x <= X_RST;
        y <= Y_RST;
      end else if (commit) begin
        x <= x_cl;
        y <= y_cl;
      end

      if (wr_ctrl) ctrl <= BUS_DATA & 8'hFD;

      if (commit && ctrl[0])       BUS_INTERRUPT_RAISE <= 1'b1;
      else if (BUS_INTERRUPT_ACK)  BUS_INTERRUPT_RAISE <= 1'b0;
    end
  end

endmodule

// File: doc/mouse_bus_io.md
Name: mouse_bus_io

Overview:
- Bus-mapped mouse peripheral; responder on the shared 8-bit processor bus, alongside RAM, ROM, Timer and the seven-segment IO.
- Consumes the decoded byte stream from the PS/2 receiver and assembles standard 3-byte mouse packets.
- Maintains clamped absolute X/Y position, button and raw-delta registers.
- Raises a processor interrupt per committed packet, held until acknowledged.

Parameters:
- BASE_ADDR, 8'hA0, first bus address of the 8-register window (A0..A7).
- X_MAX, 159, upper clamp for X position.
- Y_MAX, 119, upper clamp for Y position.
- TIMEOUT, 100000, max clock cycles between bytes inside one packet.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus; driven only during this block's read response.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  1 = processor write, 0 = read.
- RX_BYTE  in  8  byte from PS/2 receiver.
- RX_VALID  in  1  one-cycle strobe; RX_BYTE valid.
- RX_ERROR  in  1  one-cycle strobe; parity or framing error in receiver.
- BUS_INTERRUPT_RAISE  out  1  interrupt request to processor.
- BUS_INTERRUPT_ACK  in  1  one-cycle acknowledge from processor.

Behaviour:
- Clock and reset: one clock. RESET is asynchronous, active-high.
- Reset values:
  - FSM = WAIT_B0; X = X_MAX/2 (79); Y = Y_MAX/2 (59).
  - STATUS, DX and DY = 0; CTRL = 8'h01 (IRQ enabled).
  - BUS_INTERRUPT_RAISE = 0; BUS_DATA = Z; gap counter = 0.
- Register map (offset from BASE_ADDR):
  - 0 STATUS (R): last packet byte0.
  - 1 X (R).
  - 2 Y (R).
  - 3 DX (R): raw byte1.
  - 4 DY (R): raw byte2.
  - 5 CTRL (R/W): bit0 = IRQ enable, bit1 = write-1 recenter (self-clearing, reads 0).
  - 6 PKT_CNT (R): 8-bit committed-packet count, wraps 255 -> 0.
  - 7 reserved: reads 0, writes ignored.
- Bus read:
  - Address in window and BUS_WE=0 at edge N -> data and drive-enable registered.
  - BUS_DATA driven from edge N to N+1 (one-cycle latency); otherwise Z.
  - Address outside window -> never drive.
- Bus write: address in window and BUS_WE=1 at an edge -> register updated at that edge; writes to read-only offsets ignored.
- FSM states and transitions:
  - WAIT_B0: RX_VALID with RX_BYTE[3]=1 -> latch b0, go WAIT_B1. RX_BYTE[3]=0 -> discard and stay (resync).
  - WAIT_B1: RX_VALID -> latch b1, go WAIT_B2.
  - WAIT_B2: RX_VALID -> latch b2, go COMMIT.
  - COMMIT (one cycle): update all registers, go WAIT_B0. RX_VALID arriving in COMMIT is treated as byte0 of the next packet.
- Packet abort: RX_ERROR in any state, or gap counter reaching TIMEOUT in WAIT_B1/WAIT_B2 -> WAIT_B0; partial packet discarded; no register change. The gap counter clears on every accepted byte.
- Arithmetic:
  - dx = signed 9-bit {b0[4], b1}; dy = signed 9-bit {b0[5], b2}.
  - b0[6] set -> dx treated as 0; b0[7] set -> dy treated as 0.
  - X_new = X + dx; Y_new = Y - dy (PS/2 up is positive, screen Y grows downward).
  - Compute in signed 11-bit. Clamp: below 0 -> 0; above MAX -> MAX.
  - STATUS, DX and DY always take the raw bytes; PKT_CNT increments.
- Interrupt:
  - COMMIT with CTRL[0]=1 -> RAISE=1 next edge.
  - ACK -> RAISE=0.
  - ACK and COMMIT in the same cycle -> RAISE stays 1 (new event wins).
  - CTRL[0]=0 suppresses new raises only; does not clear a pending one.
- Conflicts:
  - Recenter write in the same cycle as COMMIT -> recenter wins for X/Y; STATUS, DX, DY and PKT_CNT still update.
  - Bus read coinciding with COMMIT returns the pre-commit value.

Test Plan:
- Reset, then read A1 and A2 -> BUS_DATA = 79 and 59 one cycle after the address; Z otherwise; RAISE=0.
- Bytes 08,0A,05 -> X=89, Y=54, STATUS=08, PKT_CNT=1, RAISE=1; ACK -> RAISE=0.
- Bytes 18,00,00 (dx=-256) -> X clamps to 0. Bytes 08,FF,00 repeated until past the limit -> X stops at 159, never wraps.
- Stray byte 00 then 09,01,01 -> first byte discarded; packet commits with X+1, Y-1, STATUS=09. RX_ERROR after byte1 -> no update, next valid packet commits normally.
- Byte0, then TIMEOUT+1 idle cycles, then two bytes -> no commit; the next byte is treated as byte0.
- Write A5=00 then send a packet -> no RAISE; write A5=03 -> X=79, Y=59, CTRL reads 01. ACK asserted in the COMMIT cycle -> RAISE remains 1.
